// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin or fixed-priority grant of one shared fabric,
// bridge hand-off via hreqb/hgrantb, and a watchdog that releases hung grants.
module ahb_rr_arbiter #(
  parameter int                NUM_MASTERS = 4,
  parameter int                SEL_W       = 4,
  parameter logic [SEL_W-1:0]  BRIDGE_MASK = 4'b1100,
  parameter int                RR_MODE     = 1,
  parameter int                TIMEOUT     = 16
) (
  input  logic                              hclk,
  input  logic                              hresetn,
  input  logic [NUM_MASTERS-1:0]            hreq,
  input  logic [NUM_MASTERS*SEL_W-1:0]      sel_in,
  input  logic                              hready_out,
  input  logic                              hresp,
  input  logic                              hgrantb,
  output logic [NUM_MASTERS-1:0]            hgrant,
  output logic [SEL_W-1:0]                  sel,
  output logic                              hreqb,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner,
  output logic                              busy,
  output logic                              err_pulse
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BREQ  = 2'd2,
    BXFER = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  wd_cnt;

  logic              done;
  logic              errdone;
  logic              wd_expired;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  win_next;
  logic [SEL_W-1:0]  win_sel;
  logic              win_bridge;
  logic              fin;
  logic              fin_err;

  // First requester scanning upward from ptr, wrapping modulo NUM_MASTERS.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] c;
    logic             hit;
    pick = '0;
    hit  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      c = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!hit && req[c]) begin
        hit  = 1'b1;
        pick = c;
      end
    end
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign done       = hready_out & ~hresp;
  assign errdone    = hready_out & hresp;
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    win      = (RR_MODE != 0) ? pick(hreq, rr_ptr) : pick(hreq, '0);
    win_next = (win == IDX_W'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
    win_sel  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (win == IDX_W'(m)) win_sel = sel_in[m*SEL_W +: SEL_W];
    end
    win_bridge = |(win_sel & BRIDGE_MASK);
  end

  // Exit conditions of the busy states; a normal completion beats a coincident timeout.
  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state)
      GRANT, BXFER: begin
        fin     = done;
        fin_err = ~done & (errdone | wd_expired);
      end
      BREQ: begin
        fin     = ~hreq[owner];
        fin_err = hreq[owner] & wd_expired;
      end
      default: begin
        fin     = 1'b0;
        fin_err = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      hgrant    <= '0;
      sel       <= '0;
      hreqb     <= 1'b0;
      owner     <= '0;
      err_pulse <= 1'b0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (state == IDLE) begin
        wd_cnt <= '0;
        if (|hreq) begin
          owner  <= win;
          sel    <= win_sel;
          rr_ptr <= win_next;
          if (win_bridge) begin
            state <= BREQ;
            hreqb <= 1'b1;
          end else begin
            state  <= GRANT;
            hgrant <= onehot(win);
          end
        end
      end else if (fin || fin_err) begin
        state     <= IDLE;
        hgrant    <= '0;
        sel       <= '0;
        hreqb     <= 1'b0;
        owner     <= '0;
        wd_cnt    <= '0;
        err_pulse <= fin_err;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
        case (state)
          BREQ: begin
            if (hgrantb) begin
              state  <= BXFER;
              hgrant <= onehot(owner);
            end
          end
          BXFER: begin
            // The bridge may withdraw its grant mid-transfer; mirror it one cycle later.
            hgrant <= hgrantb ? onehot(owner) : '0;
          end
          default: begin
            hgrant <= hgrant;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Table-driven scoreboard bench for ahb_rr_arbiter: one round-robin instance and
// one fixed-priority instance share the stimulus; each vector names the instance it checks.
module tb_ahb_rr_arbiter;

  localparam int TO = 6;

  logic        hclk;
  logic        hresetn;
  logic [3:0]  hreq;
  logic [15:0] sel_in;
  logic        hready_out;
  logic        hresp;
  logic        hgrantb;

  logic [3:0]  rr_gnt, fp_gnt;
  logic [3:0]  rr_sel, fp_sel;
  logic        rr_hreqb, fp_hreqb;
  logic [1:0]  rr_owner, fp_owner;
  logic        rr_busy, fp_busy;
  logic        rr_err, fp_err;

  ahb_rr_arbiter #(.NUM_MASTERS(4), .SEL_W(4), .BRIDGE_MASK(4'b1100), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
    .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .sel_in(sel_in),
    .hready_out(hready_out), .hresp(hresp), .hgrantb(hgrantb),
    .hgrant(rr_gnt), .sel(rr_sel), .hreqb(rr_hreqb), .owner(rr_owner),
    .busy(rr_busy), .err_pulse(rr_err)
  );

  ahb_rr_arbiter #(.NUM_MASTERS(4), .SEL_W(4), .BRIDGE_MASK(4'b1100), .RR_MODE(0), .TIMEOUT(TO)) u_fp (
    .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .sel_in(sel_in),
    .hready_out(hready_out), .hresp(hresp), .hgrantb(hgrantb),
    .hgrant(fp_gnt), .sel(fp_sel), .hreqb(fp_hreqb), .owner(fp_owner),
    .busy(fp_busy), .err_pulse(fp_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    bit          fp;
    logic [3:0]  hreq;
    logic [15:0] sel_in;
    logic        rdy;
    logic        resp;
    logic        gntb;
    logic [3:0]  gnt;
    logic [3:0]  sel;
    logic        hreqb;
    logic [1:0]  owner;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk;
  int   n_fail;

  localparam logic [15:0] S0 = 16'h2121;
  localparam logic [15:0] S1 = 16'h0421;
  localparam logic [15:0] S2 = 16'h8421;

  function automatic void add(bit fp, logic [3:0] rq, logic [15:0] s, logic rdy, logic resp,
                              logic gntb, logic [3:0] gnt, logic [3:0] sl, logic hb,
                              logic [1:0] own, logic bsy, logic er);
    vec_t v;
    v.fp = fp; v.hreq = rq; v.sel_in = s; v.rdy = rdy; v.resp = resp; v.gntb = gntb;
    v.gnt = gnt; v.sel = sl; v.hreqb = hb; v.owner = own; v.busy = bsy; v.err = er;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec%0d: actual %0h required %0h", nm, id, act, req);
    end
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      v          = tbl[i];
      hreq       = v.hreq;
      sel_in     = v.sel_in;
      hready_out = v.rdy;
      hresp      = v.resp;
      hgrantb    = v.gntb;
      exp_q.push_back(v);
      @(posedge hclk);
      @(negedge hclk);
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, i, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.fp) begin
          chk({tag, "_fp_hgrant"}, i, fp_gnt, e.gnt);
          chk({tag, "_fp_sel"}, i, fp_sel, e.sel);
          chk({tag, "_fp_hreqb"}, i, fp_hreqb, e.hreqb);
          chk({tag, "_fp_busy"}, i, fp_busy, e.busy);
          chk({tag, "_fp_err"}, i, fp_err, e.err);
          if (e.busy) chk({tag, "_fp_owner"}, i, fp_owner, e.owner);
        end else begin
          chk({tag, "_rr_hgrant"}, i, rr_gnt, e.gnt);
          chk({tag, "_rr_sel"}, i, rr_sel, e.sel);
          chk({tag, "_rr_hreqb"}, i, rr_hreqb, e.hreqb);
          chk({tag, "_rr_busy"}, i, rr_busy, e.busy);
          chk({tag, "_rr_err"}, i, rr_err, e.err);
          if (e.busy) chk({tag, "_rr_owner"}, i, rr_owner, e.owner);
        end
      end
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    hresetn    = 1'b0;
    hreq       = '0;
    sel_in     = '0;
    hready_out = 1'b0;
    hresp      = 1'b0;
    hgrantb    = 1'b0;
    repeat (2) @(negedge hclk);
    chk("rst_rr_hgrant", 0, rr_gnt, 0);
    chk("rst_rr_sel", 0, rr_sel, 0);
    chk("rst_rr_hreqb", 0, rr_hreqb, 0);
    chk("rst_rr_busy", 0, rr_busy, 0);
    chk("rst_rr_err", 0, rr_err, 0);
    chk("rst_rr_owner", 0, rr_owner, 0);
    chk("rst_fp_hgrant", 0, fp_gnt, 0);
    chk("rst_fp_busy", 0, fp_busy, 0);
    hresetn = 1'b1;

    // Round-robin with all four requesting, every grant completed immediately.
    add(0, 4'hF, S0, 1, 0, 0, 4'b0001, 4'h1, 0, 2'd0, 1, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0010, 4'h2, 0, 2'd1, 1, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0100, 4'h1, 0, 2'd2, 1, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b1000, 4'h2, 0, 2'd3, 1, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0001, 4'h1, 0, 2'd0, 1, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Pointer wraps to master 0; hreq dropped mid-grant; ERROR completion.
    add(0, 4'h1, S0, 0, 0, 0, 4'b0001, 4'h1, 0, 2'd0, 1, 0);
    add(0, 4'h0, S0, 0, 0, 0, 4'b0001, 4'h1, 0, 2'd0, 1, 0);
    add(0, 4'h0, S0, 1, 1, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 1);
    add(0, 4'h0, S0, 0, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Bridge target from master 2, bridge grant after three cycles.
    add(0, 4'h4, S1, 0, 0, 0, 4'b0000, 4'h4, 1, 2'd2, 1, 0);
    add(0, 4'h4, S1, 0, 0, 0, 4'b0000, 4'h4, 1, 2'd2, 1, 0);
    add(0, 4'h4, S1, 0, 0, 0, 4'b0000, 4'h4, 1, 2'd2, 1, 0);
    add(0, 4'h4, S1, 0, 0, 1, 4'b0100, 4'h4, 1, 2'd2, 1, 0);
    add(0, 4'h0, S1, 1, 0, 1, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    add(0, 4'h0, S1, 0, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Hung grant to master 0: held TO cycles, released with err_pulse, then master 1.
    for (int k = 0; k < TO; k++) add(0, 4'h3, S1, 0, 0, 0, 4'b0001, 4'h1, 0, 2'd0, 1, 0);
    add(0, 4'h3, S1, 0, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 1);
    add(0, 4'h3, S1, 0, 0, 0, 4'b0010, 4'h2, 0, 2'd1, 1, 0);
    add(0, 4'h0, S1, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Completion on the very cycle the watchdog expires is a clean completion.
    for (int k = 0; k < TO; k++) add(0, 4'h2, S1, 0, 0, 0, 4'b0010, 4'h2, 0, 2'd1, 1, 0);
    add(0, 4'h0, S1, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Master 3 abandons its bridge request.
    add(0, 4'h8, S2, 0, 0, 0, 4'b0000, 4'h8, 1, 2'd3, 1, 0);
    add(0, 4'h0, S2, 0, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Into BXFER for the asynchronous reset check.
    add(0, 4'h4, S1, 0, 0, 0, 4'b0000, 4'h4, 1, 2'd2, 1, 0);
    add(0, 4'h4, S1, 0, 0, 1, 4'b0100, 4'h4, 1, 2'd2, 1, 0);
    run_table("p1");

    // Reset asserted between clock edges must clear outputs at once.
    #2;
    hresetn = 1'b0;
    #1;
    chk("async_rst_hgrant", 0, rr_gnt, 0);
    chk("async_rst_hreqb", 0, rr_hreqb, 0);
    chk("async_rst_sel", 0, rr_sel, 0);
    chk("async_rst_busy", 0, rr_busy, 0);
    hreq    = '0;
    hgrantb = 1'b0;
    @(negedge hclk);
    chk("rst_hold_hgrant", 1, rr_gnt, 0);
    @(negedge hclk);
    hresetn = 1'b1;

    tbl.delete();
    // Pointer restarts at master 0 after reset.
    add(0, 4'hF, S0, 1, 0, 0, 4'b0001, 4'h1, 0, 2'd0, 1, 0);
    add(0, 4'hF, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    // Fixed priority: master 1 always wins over master 2.
    for (int k = 0; k < 3; k++) begin
      add(1, 4'h6, S0, 1, 0, 0, 4'b0010, 4'h2, 0, 2'd1, 1, 0);
      add(1, 4'h6, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    end
    add(1, 4'h4, S0, 1, 0, 0, 4'b0100, 4'h1, 0, 2'd2, 1, 0);
    add(1, 4'h0, S0, 1, 0, 0, 4'b0000, 4'h0, 0, 2'd0, 0, 0);
    run_table("p2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
